// File: rtl/seg7_pkg.sv
// Glyph codes, font selection and segment decode shared by the scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [3:0] CODE_C_T = 4'd10;
  localparam logic [3:0] CODE_DASH = 4'd11;
  localparam logic [3:0] CODE_D_B = 4'd12;
  localparam logic [3:0] CODE_L = 4'd13;
  localparam logic [3:0] CODE_E = 4'd14;
  localparam logic [3:0] CODE_R = 4'd15;

  typedef enum logic {
    FONT_STD  = 1'b0,
    FONT_TEST = 1'b1
  } font_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7_decode(input logic [3:0] code, input font_e font);
    logic [6:0] seg;
    case (code)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      CODE_C_T: seg = (font == FONT_TEST) ? 7'b0000111 : 7'b1000110;
      CODE_DASH: seg = 7'b0111111;
      CODE_D_B: seg = (font == FONT_TEST) ? 7'b0000011 : 7'b0100001;
      CODE_L: seg = 7'b1000111;
      CODE_E: seg = 7'b0000110;
      CODE_R: seg = 7'b0101111;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph lookup for the digit currently being scanned.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       font_sel,
  output logic [6:0] seg
);

  assign seg = seg7_decode(code, font_e'(font_sel));

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with PWM dimming, per-digit blink
// and frame-aligned input snapshots so a frame never mixes old and new data.
module seven_segment_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_LOG2 = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] nums,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    font_sel,
  input  logic [3:0]              brightness,
  output logic [6:0]              display,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);
  localparam logic [REFRESH_LOG2-1:0] DIV_ONE = REFRESH_LOG2'(1);
  localparam logic [NUM_DIGITS-1:0] ANODE_ONE = NUM_DIGITS'(1);

  logic [REFRESH_LOG2-1:0] div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [BLINK_W-1:0]      blink_cnt;
  logic                    blink_phase;
  logic [3:0]              code_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   dp_en_s;
  logic [NUM_DIGITS-1:0]   blink_en_s;
  logic                    font_s;
  logic                    snap_valid;

  logic       slot_end;
  logic       wrap;
  logic       pwm_on;
  logic       lit;
  logic [6:0] glyph;

  assign slot_end = &div_cnt;
  assign wrap     = slot_end && (idx == IDX_LAST);
  assign pwm_on   = div_cnt[REFRESH_LOG2-1 -: 4] < brightness;
  // Cycle 0 of every slot keeps anodes off so the previous digit cannot ghost.
  assign lit      = pwm_on && (div_cnt != '0) && !(blink_en_s[idx] && !blink_phase);

  seg7_glyph_rom u_glyph_rom (
    .code     (code_s[idx]),
    .font_sel (font_s),
    .seg      (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      code_s      <= '{default: 4'hF};
      dp_en_s     <= '0;
      blink_en_s  <= '0;
      font_s      <= 1'b0;
      snap_valid  <= 1'b0;
      frame_tick  <= 1'b0;
      digit       <= '1;
      display     <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      div_cnt    <= div_cnt + DIV_ONE;
      frame_tick <= wrap;
      if (slot_end) idx <= wrap ? '0 : idx + IDX_ONE;
      if (wrap) begin
        for (int i = 0; i < NUM_DIGITS; i++) code_s[i] <= nums[4*i +: 4];
        dp_en_s    <= dp_en;
        blink_en_s <= blink_en;
        font_s     <= font_sel;
        snap_valid <= 1'b1;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_ONE;
        end
      end
      // Segments stay driven while the anode is off; the snapshot is blank until the first wrap.
      digit   <= lit ? ~(ANODE_ONE << idx) : '1;
      display <= snap_valid ? glyph : SEG_BLANK;
      dp      <= ~dp_en_s[idx];
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Frame-aligned scoreboard bench for the scan driver (4 digits, 32-cycle slots, 2-frame blink).
module tb_seven_segment_scan_driver;

  localparam int ND = 4;
  localparam int RL = 5;
  localparam int BF = 2;
  localparam int SLOT = 32;
  localparam int FRAME = SLOT * ND;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   nums;
  logic [3:0]    dp_en;
  logic [3:0]    blink_en;
  logic          font_sel;
  logic [3:0]    brightness;
  logic [6:0]    display;
  logic          dp;
  logic [3:0]    digit;
  logic          frame_tick;

  typedef struct {
    logic [3:0] digit;
    logic [6:0] display;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] s_nums;
  logic [3:0]  s_dp;
  logic [3:0]  s_blink;
  logic        s_font;
  int          bcnt;
  logic        bphase;

  seven_segment_scan_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_LOG2 (RL),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .nums       (nums),
    .dp_en      (dp_en),
    .blink_en   (blink_en),
    .font_sel   (font_sel),
    .brightness (brightness),
    .display    (display),
    .dp         (dp),
    .digit      (digit),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] code, input logic font);
    case (code)
      4'd0:  return 7'b1000000;
      4'd1:  return 7'b1111001;
      4'd2:  return 7'b0100100;
      4'd3:  return 7'b0110000;
      4'd4:  return 7'b0011001;
      4'd5:  return 7'b0010010;
      4'd6:  return 7'b0000010;
      4'd7:  return 7'b1111000;
      4'd8:  return 7'b0000000;
      4'd9:  return 7'b0010000;
      4'd10: return font ? 7'b0000111 : 7'b1000110;
      4'd11: return 7'b0111111;
      4'd12: return font ? 7'b0000011 : 7'b0100001;
      4'd13: return 7'b1000111;
      4'd14: return 7'b0000110;
      default: return 7'b0101111;
    endcase
  endfunction

  // Called on the sampled cycle where frame_tick is high: the wrap just latched inputs.
  task automatic note_tick();
    s_nums  = nums;
    s_dp    = dp_en;
    s_blink = blink_en;
    s_font  = font_sel;
    if (bcnt == BF - 1) begin
      bcnt   = 0;
      bphase = ~bphase;
    end else begin
      bcnt++;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_display", 32'(display), 32'h7F);
    check("rst_digit", 32'(digit), 32'hF);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);
  endtask

  task automatic count_to_tick();
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < FRAME + 64) begin
      @(negedge clk);
      n++;
      check("blank_first_frame", 32'(display), 32'h7F);
      if (frame_tick) seen = 1;
    end
    check("first_tick_latency", n, FRAME);
    if (seen) note_tick();
  endtask

  // Starts on a frame_tick cycle; checks the 128 output cycles of the frame that follows.
  task automatic check_frame(input int chg_t, input logic chg_font, output int lit_cycles);
    exp_t       e;
    logic [3:0] one = 4'b0001;
    logic [4:0] jj;
    bit         on;
    lit_cycles = 0;
    for (int k = 0; k < ND; k++) begin
      for (int j = 0; j < SLOT; j++) begin
        jj = 5'(j);
        on = (jj[4:1] < brightness) && (jj != 0) && !(s_blink[k] && !bphase);
        e.digit   = on ? ~(one << k) : 4'hF;
        e.display = ref_glyph(s_nums[4*k +: 4], s_font);
        e.dp      = ~s_dp[k];
        e.tick    = (k == ND - 1) && (j == SLOT - 1);
        sb.push_back(e);
      end
    end
    for (int t = 1; t <= FRAME; t++) begin
      @(negedge clk);
      e = sb.pop_front();
      check("digit", 32'(digit), 32'(e.digit));
      check("display", 32'(display), 32'(e.display));
      check("dp", 32'(dp), 32'(e.dp));
      check("frame_tick", 32'(frame_tick), 32'(e.tick));
      if (digit != 4'hF) lit_cycles++;
      if (t == chg_t) font_sel = chg_font;
    end
    note_tick();
  endtask

  int lc;

  initial begin
    rst        = 1'b1;
    nums       = 16'h1234;
    dp_en      = 4'b0000;
    blink_en   = 4'b0000;
    font_sel   = 1'b0;
    brightness = 4'd15;
    bcnt       = 0;
    bphase     = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst = 1'b0;

    count_to_tick();
    check_frame(0, 1'b0, lc);
    check("lit_cycles_br15", lc, 4 * 29);

    // New codes land one frame late; the font change mid-frame must wait for the next wrap.
    nums = 16'hACDE;
    check_frame(0, 1'b0, lc);
    check_frame(64, 1'b1, lc);
    check_frame(0, 1'b0, lc);

    brightness = 4'd4;
    check_frame(0, 1'b0, lc);
    check("lit_cycles_br4", lc, 4 * 7);
    brightness = 4'd0;
    check_frame(0, 1'b0, lc);
    check("lit_cycles_br0", lc, 0);

    brightness = 4'd15;
    nums       = 16'h5678;
    blink_en   = 4'b0001;
    dp_en      = 4'b0100;
    for (int f = 0; f < 5; f++) check_frame(0, 1'b0, lc);

    nums = 16'h90B9;
    check_frame(0, 1'b0, lc);
    for (int i = 0; i < 70; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst    = 1'b0;
    bcnt   = 0;
    bphase = 1'b1;
    count_to_tick();
    check_frame(0, 1'b0, lc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
